// File: rtl/rtc_time_counter_if.sv
// Bus interface for rtc_time_counter: run/load control, load fields, time and pulse outputs.
// The alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_time_counter_if #(
    parameter int HW = 5,
    parameter int MW = 6,
    parameter int SW = 6
);
    logic          run;
    logic          load;
    logic [HW-1:0] load_hour;
    logic [MW-1:0] load_min;
    logic [SW-1:0] load_sec;
    logic [HW-1:0] out_hour;
    logic [MW-1:0] out_min;
    logic [SW-1:0] out_sec;
    logic          sec_pulse;
    logic          min_pulse;
    logic          day_pulse;
    logic          load_err;
`ifdef RTC_ALARM_EN
    logic          alarm_wr;
    logic [HW-1:0] alarm_hour;
    logic [MW-1:0] alarm_min;
    logic          alarm_arm;
    logic          alarm_hit;
`endif

`ifdef RTC_ALARM_EN
    modport master (
        output run, load, load_hour, load_min, load_sec,
        output alarm_wr, alarm_hour, alarm_min, alarm_arm,
        input  out_hour, out_min, out_sec, sec_pulse, min_pulse, day_pulse, load_err,
        input  alarm_hit
    );
    modport slave (
        input  run, load, load_hour, load_min, load_sec,
        input  alarm_wr, alarm_hour, alarm_min, alarm_arm,
        output out_hour, out_min, out_sec, sec_pulse, min_pulse, day_pulse, load_err,
        output alarm_hit
    );
`else
    modport master (
        output run, load, load_hour, load_min, load_sec,
        input  out_hour, out_min, out_sec, sec_pulse, min_pulse, day_pulse, load_err
    );
    modport slave (
        input  run, load, load_hour, load_min, load_sec,
        output out_hour, out_min, out_sec, sec_pulse, min_pulse, day_pulse, load_err
    );
`endif
endinterface

// File: rtl/rtc_time_counter.sv
// hh:mm:ss time-of-day counter with prescaler, run/stop, synchronous load and
// same-cycle carry pulses. Optional alarm comparator enabled by macro RTC_ALARM_EN.
// The interface instance must be sized with HW/MW/SW = $clog2(MAX+1) of the matching fields.
module rtc_time_counter #(
    parameter int CLK_DIV  = 50_000_000,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input logic              clk,
    input logic              reset,
    rtc_time_counter_if.slave bus
);
    localparam int SW = $clog2(SEC_MAX + 1);
    localparam int MW = $clog2(MIN_MAX + 1);
    localparam int HW = $clog2(HOUR_MAX + 1);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [SW-1:0] SEC_MAX_V  = SW'(SEC_MAX);
    localparam logic [MW-1:0] MIN_MAX_V  = MW'(MIN_MAX);
    localparam logic [HW-1:0] HOUR_MAX_V = HW'(HOUR_MAX);
    localparam logic [PW-1:0] PRESC_TOP  = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [MW-1:0] min_q, min_d;
    logic [HW-1:0] hour_q, hour_d;
    logic          sec_pulse_q, sec_pulse_d;
    logic          min_pulse_q, min_pulse_d;
    logic          day_pulse_q, day_pulse_d;
    logic          load_err_q, load_err_d;
    logic          tick;
    logic          load_ok;
    logic          advance;
`ifdef RTC_ALARM_EN
    logic [HW-1:0] alarm_hour_q, alarm_hour_d;
    logic [MW-1:0] alarm_min_q, alarm_min_d;
    logic          alarm_hit_q, alarm_hit_d;
    logic          alarm_ok;
`endif

    // Tick and load qualification; a tick is discarded whenever a valid load lands in the same cycle
    always_comb begin
        tick    = bus.run && (presc_q == PRESC_TOP);
        load_ok = bus.load && (bus.load_hour <= HOUR_MAX_V) &&
                  (bus.load_min <= MIN_MAX_V) && (bus.load_sec <= SEC_MAX_V);
        advance = tick && !load_ok;
    end

    // Next-state: load has priority, otherwise prescaler advance and same-cycle sec/min/hour carry
    always_comb begin
        presc_d     = presc_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        sec_pulse_d = 1'b0;
        min_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        load_err_d  = bus.load && !load_ok;
        if (load_ok) begin
            presc_d = '0;
            sec_d   = bus.load_sec;
            min_d   = bus.load_min;
            hour_d  = bus.load_hour;
        end else if (bus.run) begin
            if (tick) begin
                presc_d     = '0;
                sec_pulse_d = 1'b1;
                if (sec_q < SEC_MAX_V) begin
                    sec_d = sec_q + 1'b1;
                end else begin
                    sec_d       = '0;
                    min_pulse_d = 1'b1;
                    if (min_q < MIN_MAX_V) begin
                        min_d = min_q + 1'b1;
                    end else begin
                        min_d = '0;
                        if (hour_q < HOUR_MAX_V) begin
                            hour_d = hour_q + 1'b1;
                        end else begin
                            hour_d      = '0;
                            day_pulse_d = 1'b1;
                        end
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

`ifdef RTC_ALARM_EN
    // Alarm capture and match: only a tick reaching alarm_hour:alarm_min:00 fires, never a load
    always_comb begin
        alarm_ok     = bus.alarm_wr && (bus.alarm_hour <= HOUR_MAX_V) && (bus.alarm_min <= MIN_MAX_V);
        alarm_hour_d = alarm_ok ? bus.alarm_hour : alarm_hour_q;
        alarm_min_d  = alarm_ok ? bus.alarm_min  : alarm_min_q;
        alarm_hit_d  = advance && bus.alarm_arm && (hour_d == alarm_hour_q) &&
                       (min_d == alarm_min_q) && (sec_d == '0);
    end
`endif

    // State register: counters, prescaler and pulses all reset synchronously
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            sec_pulse_q <= 1'b0;
            min_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            sec_pulse_q <= sec_pulse_d;
            min_pulse_q <= min_pulse_d;
            day_pulse_q <= day_pulse_d;
`ifdef RTC_ALARM_EN
            load_err_q  <= load_err_d || (bus.alarm_wr && !alarm_ok);
`else
            load_err_q  <= load_err_d;
`endif
        end
    end

`ifdef RTC_ALARM_EN
    // Alarm registers: reset clears the alarm time and any pending hit
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            alarm_hit_q  <= 1'b0;
        end else begin
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            alarm_hit_q  <= alarm_hit_d;
        end
    end

    assign bus.alarm_hit = alarm_hit_q;
`endif

    assign bus.out_hour  = hour_q;
    assign bus.out_min   = min_q;
    assign bus.out_sec   = sec_q;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.min_pulse = min_pulse_q;
    assign bus.day_pulse = day_pulse_q;
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter with CLK_DIV=4 and default field limits.
// Alarm scenarios are compiled only when RTC_ALARM_EN is defined.
module tb_rtc_time_counter;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    rtc_time_counter_if #(.HW(5), .MW(6), .SW(6)) ifc ();

    rtc_time_counter #(.CLK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        ifc.load      = 1'b1;
        ifc.load_hour = h;
        ifc.load_min  = m;
        ifc.load_sec  = s;
        step(1);
        ifc.load = 1'b0;
    endtask

    // pulses packed as {sec_pulse, min_pulse, day_pulse, load_err}
    function automatic logic [3:0] pulses();
        return {ifc.sec_pulse, ifc.min_pulse, ifc.day_pulse, ifc.load_err};
    endfunction

    function automatic logic [16:0] now_t();
        return {ifc.out_hour, ifc.out_min, ifc.out_sec};
    endfunction

    function automatic logic [16:0] mk_t(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if (now_t() !== mk_t(0, 0, 0)) begin
            errors++; $display("FAIL reset_time: got %h want %h", now_t(), mk_t(0, 0, 0));
        end
        checks++;
        if (pulses() !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b want 0000", pulses());
        end
        ifc.run = 1'b1;
        step(3);
        checks++;
        if (ifc.out_sec !== 6'd0 || ifc.sec_pulse !== 1'b0) begin
            errors++; $display("FAIL pre_first_tick: got sec=%0d sp=%b want sec=0 sp=0", ifc.out_sec, ifc.sec_pulse);
        end
        step(1);
        checks++;
        if (ifc.out_sec !== 6'd1 || pulses() !== 4'b1000) begin
            errors++; $display("FAIL first_tick: got sec=%0d p=%b want sec=1 p=1000", ifc.out_sec, pulses());
        end
        step(1);
        checks++;
        if (ifc.sec_pulse !== 1'b0) begin
            errors++; $display("FAIL sec_pulse_width: got %b want 0", ifc.sec_pulse);
        end
        step(3);
        checks++;
        if (ifc.out_sec !== 6'd2 || ifc.sec_pulse !== 1'b1) begin
            errors++; $display("FAIL second_tick: got sec=%0d sp=%b want sec=2 sp=1", ifc.out_sec, ifc.sec_pulse);
        end
    endtask

    task automatic test_min_carry();
        ifc.run = 1'b0;
        do_load(5'd0, 6'd0, 6'd59);
        checks++;
        if (now_t() !== mk_t(0, 0, 59) || pulses() !== 4'b0000) begin
            errors++; $display("FAIL load_ok: got %h p=%b want %h p=0000", now_t(), pulses(), mk_t(0, 0, 59));
        end
        ifc.run = 1'b1;
        step(3);
        checks++;
        if (ifc.out_sec !== 6'd59) begin
            errors++; $display("FAIL carry_early: got sec=%0d want 59", ifc.out_sec);
        end
        step(1);
        checks++;
        if (now_t() !== mk_t(0, 1, 0) || pulses() !== 4'b1100) begin
            errors++; $display("FAIL min_carry: got %h p=%b want %h p=1100", now_t(), pulses(), mk_t(0, 1, 0));
        end
    endtask

    task automatic test_day_wrap();
        ifc.run = 1'b0;
        do_load(5'd23, 6'd59, 6'd59);
        ifc.run = 1'b1;
        step(4);
        checks++;
        if (now_t() !== mk_t(0, 0, 0) || pulses() !== 4'b1110) begin
            errors++; $display("FAIL day_wrap: got %h p=%b want %h p=1110", now_t(), pulses(), mk_t(0, 0, 0));
        end
        step(1);
        checks++;
        if (ifc.day_pulse !== 1'b0) begin
            errors++; $display("FAIL day_pulse_width: got %b want 0", ifc.day_pulse);
        end
    endtask

    task automatic test_load_err();
        ifc.run = 1'b0;
        do_load(5'd24, 6'd0, 6'd0);
        checks++;
        if (now_t() !== mk_t(0, 0, 0) || pulses() !== 4'b0001) begin
            errors++; $display("FAIL bad_hour: got %h p=%b want %h p=0001", now_t(), pulses(), mk_t(0, 0, 0));
        end
        step(1);
        checks++;
        if (ifc.load_err !== 1'b0) begin
            errors++; $display("FAIL load_err_width: got %b want 0", ifc.load_err);
        end
        do_load(5'd0, 6'd60, 6'd0);
        checks++;
        if (now_t() !== mk_t(0, 0, 0) || pulses() !== 4'b0001) begin
            errors++; $display("FAIL bad_min: got %h p=%b want %h p=0001", now_t(), pulses(), mk_t(0, 0, 0));
        end
    endtask

    task automatic test_load_in_tick();
        ifc.run = 1'b0;
        do_load(5'd0, 6'd0, 6'd0);
        ifc.run = 1'b1;
        step(3);
        do_load(5'd5, 6'd6, 6'd7);
        checks++;
        if (now_t() !== mk_t(5, 6, 7) || pulses() !== 4'b0000) begin
            errors++; $display("FAIL load_beats_tick: got %h p=%b want %h p=0000", now_t(), pulses(), mk_t(5, 6, 7));
        end
        step(3);
        checks++;
        if (ifc.out_sec !== 6'd7) begin
            errors++; $display("FAIL after_load_early: got sec=%0d want 7", ifc.out_sec);
        end
        step(1);
        checks++;
        if (now_t() !== mk_t(5, 6, 8) || ifc.sec_pulse !== 1'b1) begin
            errors++; $display("FAIL after_load_tick: got %h sp=%b want %h sp=1", now_t(), ifc.sec_pulse, mk_t(5, 6, 8));
        end
    endtask

    task automatic test_run_hold();
        step(2);
        ifc.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if (now_t() !== mk_t(5, 6, 8) || ifc.sec_pulse !== 1'b0) begin
                errors++; $display("FAIL hold_%0d: got %h sp=%b want %h sp=0", i, now_t(), ifc.sec_pulse, mk_t(5, 6, 8));
            end
        end
        ifc.run = 1'b1;
        step(1);
        checks++;
        if (ifc.out_sec !== 6'd8) begin
            errors++; $display("FAIL resume_early: got sec=%0d want 8", ifc.out_sec);
        end
        step(1);
        checks++;
        if (ifc.out_sec !== 6'd9 || ifc.sec_pulse !== 1'b1) begin
            errors++; $display("FAIL resume_tick: got sec=%0d sp=%b want sec=9 sp=1", ifc.out_sec, ifc.sec_pulse);
        end
    endtask

    task automatic test_bad_load_in_tick();
        step(3);
        do_load(5'd30, 6'd0, 6'd0);
        checks++;
        if (now_t() !== mk_t(5, 6, 10) || pulses() !== 4'b1001) begin
            errors++; $display("FAIL bad_load_tick: got %h p=%b want %h p=1001", now_t(), pulses(), mk_t(5, 6, 10));
        end
    endtask

    task automatic test_reset_mid();
        step(2);
        reset         = 1'b1;
        ifc.load      = 1'b1;
        ifc.load_hour = 5'd3;
        ifc.load_min  = 6'd4;
        ifc.load_sec  = 6'd5;
        step(1);
        reset    = 1'b0;
        ifc.load = 1'b0;
        checks++;
        if (now_t() !== mk_t(0, 0, 0) || pulses() !== 4'b0000) begin
            errors++; $display("FAIL reset_wins: got %h p=%b want %h p=0000", now_t(), pulses(), mk_t(0, 0, 0));
        end
        step(3);
        checks++;
        if (ifc.out_sec !== 6'd0) begin
            errors++; $display("FAIL reset_presc_early: got sec=%0d want 0", ifc.out_sec);
        end
        step(1);
        checks++;
        if (ifc.out_sec !== 6'd1) begin
            errors++; $display("FAIL reset_presc_tick: got sec=%0d want 1", ifc.out_sec);
        end
    endtask

`ifdef RTC_ALARM_EN
    task automatic test_alarm();
        ifc.run        = 1'b0;
        ifc.alarm_wr   = 1'b1;
        ifc.alarm_hour = 5'd1;
        ifc.alarm_min  = 6'd2;
        ifc.alarm_arm  = 1'b1;
        step(1);
        ifc.alarm_wr = 1'b0;
        do_load(5'd1, 6'd1, 6'd59);
        ifc.run = 1'b1;
        step(4);
        checks++;
        if (now_t() !== mk_t(1, 2, 0) || ifc.alarm_hit !== 1'b1) begin
            errors++; $display("FAIL alarm_fire: got %h hit=%b want %h hit=1", now_t(), ifc.alarm_hit, mk_t(1, 2, 0));
        end
        ifc.run = 1'b0;
        do_load(5'd1, 6'd2, 6'd0);
        checks++;
        if (ifc.alarm_hit !== 1'b0) begin
            errors++; $display("FAIL alarm_on_load: got %b want 0", ifc.alarm_hit);
        end
        ifc.alarm_wr   = 1'b1;
        ifc.alarm_hour = 5'd24;
        step(1);
        ifc.alarm_wr = 1'b0;
        checks++;
        if (ifc.load_err !== 1'b1) begin
            errors++; $display("FAIL alarm_bad_wr: got %b want 1", ifc.load_err);
        end
        do_load(5'd1, 6'd1, 6'd59);
        ifc.run = 1'b1;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        do_load(5'd1, 6'd1, 6'd59);
        for (int i = 0; i < 6; i++) begin
            step(1);
            checks++;
            if (ifc.alarm_hit !== 1'b0) begin
                errors++; $display("FAIL alarm_after_reset_%0d: got %b want 0", i, ifc.alarm_hit);
            end
        end
    endtask
`endif

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b0;
        ifc.run       = 1'b0;
        ifc.load      = 1'b0;
        ifc.load_hour = '0;
        ifc.load_min  = '0;
        ifc.load_sec  = '0;
`ifdef RTC_ALARM_EN
        ifc.alarm_wr   = 1'b0;
        ifc.alarm_hour = '0;
        ifc.alarm_min  = '0;
        ifc.alarm_arm  = 1'b0;
`endif
        #2;
        test_reset();
        test_min_carry();
        test_day_wrap();
        test_load_err();
        test_load_in_tick();
        test_run_hold();
        test_bad_load_in_tick();
        test_reset_mid();
`ifdef RTC_ALARM_EN
        test_alarm();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
